// File: rtl/alu_share_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// The winner's operands are registered, the ALU result is captured one cycle later,
// and the result is returned on a valid/ready response channel tagged with the winner.
module alu_share_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    input  logic [4*NREQ-1:0]  req_op,
    input  logic [5*NREQ-1:0]  req_shamt,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [3:0]         alu_op,
    output logic [4:0]         alu_shamt,
    input  logic [31:0]        alu_result,
    input  logic               alu_zero,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_id,
    output logic [31:0]        rsp_result,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic               busy,
    output logic [CNT_W-1:0]   op_count
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [4:0]         shamt_q, shamt_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_id_q, rsp_id_d;
    logic [31:0]        rsp_result_q, rsp_result_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   op_count_q, op_count_d;

    logic               win_vld;
    logic               win_id;
    logic               other_id;
    logic [3:0]         shamt_base;
    logic               op_legal;

    // Round-robin pick: the requester not granted last time has priority.
    always_comb begin
        other_id = ~last_grant_q;
        win_vld  = 1'b0;
        win_id   = last_grant_q;
        if (req_valid[other_id]) begin
            win_vld = 1'b1;
            win_id  = other_id;
        end else if (req_valid[last_grant_q]) begin
            win_vld = 1'b1;
            win_id  = last_grant_q;
        end
        shamt_base = win_id ? 4'd5 : 4'd0;
    end

    // Op codes the ALU actually implements; anything else returns an error response.
    always_comb begin
        unique case (op_q)
            4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b0101: op_legal = 1'b1;
            default:                                              op_legal = 1'b0;
        endcase
    end

    // Next-state and accept logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        shamt_d      = shamt_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        op_count_d   = op_count_q;
        req_ready    = '0;
        unique case (state_q)
            StIdle: begin
                if (win_vld) begin
                    req_ready[win_id] = 1'b1;
                    a_d               = req_a[{win_id, 5'd0} +: 32];
                    b_d               = req_b[{win_id, 5'd0} +: 32];
                    op_d              = req_op[{win_id, 2'd0} +: 4];
                    shamt_d           = req_shamt[shamt_base +: 5];
                    last_grant_d      = win_id;
                    rsp_id_d          = win_id;
                    state_d           = StExec;
                end
            end
            StExec: begin
                rsp_valid_d = 1'b1;
                // Illegal ops leave alu_result undefined, so never capture it.
                if (op_legal) begin
                    rsp_result_d = alu_result;
                    rsp_zero_d   = alu_zero;
                    rsp_err_d    = 1'b0;
                end else begin
                    rsp_result_d = '0;
                    rsp_zero_d   = 1'b0;
                    rsp_err_d    = 1'b1;
                end
                state_d = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            shamt_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            shamt_q      <= shamt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            op_count_q   <= op_count_d;
        end
    end

    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_op     = op_q;
    assign alu_shamt  = shamt_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != StIdle);
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model. A second instance with a 4-bit counter
// exercises counter wrap-around within a short run.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a, req_b;
    logic [7:0]  req_op;
    logic [9:0]  req_shamt;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
    logic [31:0] rsp_result;
    logic [15:0] op_count;

    logic [1:0]  w_req_ready;
    logic [31:0] w_alu_a, w_alu_b, w_rsp_result;
    logic [3:0]  w_alu_op;
    logic [4:0]  w_alu_shamt;
    logic        w_rsp_valid, w_rsp_id, w_rsp_zero, w_rsp_err, w_busy;
    logic [3:0]  w_op_count;

    logic [31:0] pa[2];
    logic [31:0] pb[2];
    logic [3:0]  pop[2];
    logic [4:0]  psh[2];

    int checks = 0;
    int failures = 0;
    int model_count = 0;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        zero;
        logic        err;
    } rsp_t;

    always #5 clk = ~clk;

    assign req_a     = {pa[1], pa[0]};
    assign req_b     = {pb[1], pb[0]};
    assign req_op    = {pop[1], pop[0]};
    assign req_shamt = {psh[1], psh[0]};

    // Behavioural ALU standing in for the real one.
    function automatic logic ref_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd4, 4'd5};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic [4:0] sh);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd4:    return b << sh;
            4'd5:    return b >> sh;
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result = ref_legal(alu_op) ? ref_alu(alu_a, alu_b, alu_op, alu_shamt) : 32'hxxxxxxxx;
    assign alu_zero   = ref_legal(alu_op) ? (alu_result == 32'd0) : 1'bx;

    alu_share_arbiter #(.NREQ(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_shamt(req_shamt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy), .op_count(op_count)
    );

    // Narrow-counter copy sees identical traffic; its ALU inputs equal the main instance's.
    alu_share_arbiter #(.NREQ(2), .CNT_W(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(w_req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_shamt(req_shamt),
        .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_op(w_alu_op), .alu_shamt(w_alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(w_rsp_id),
        .rsp_result(w_rsp_result), .rsp_zero(w_rsp_zero), .rsp_err(w_rsp_err),
        .busy(w_busy), .op_count(w_op_count)
    );

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pa[i] = '0; pb[i] = '0; pop[i] = '0; psh[i] = '0;
        end
        repeat (2) @(negedge clk);
        rst_n       = 1'b1;
        model_count = 0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy, op_count,
             alu_a, alu_b, alu_op, alu_shamt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b id=%b res=%h zero=%b err=%b busy=%b cnt=%h a=%h b=%h op=%h sh=%h, want all zero",
                     rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy, op_count,
                     alu_a, alu_b, alu_op, alu_shamt);
        end
        checks++;
        if (req_ready !== 2'b00) begin
            failures++;
            $display("FAIL reset_ready: got %b want 00", req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        pa[0] = 32'd5; pb[0] = 32'd7; pop[0] = 4'b0010;
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++; $display("FAIL basic_ready: got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if ({busy, rsp_valid, alu_a, alu_b, alu_op} !== {1'b1, 1'b0, 32'd5, 32'd7, 4'b0010}) begin
            failures++;
            $display("FAIL basic_exec: got busy=%b valid=%b a=%0d b=%0d op=%h want 1 0 5 7 2",
                     busy, rsp_valid, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err} !== {1'b1, 32'd12, 3'b000}) begin
            failures++;
            $display("FAIL basic_rsp: got valid=%b res=%0d zero=%b id=%b err=%b want 1 12 0 0 0",
                     rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, busy, op_count, alu_a} !== {2'b00, 16'd1, 32'd5}) begin
            failures++;
            $display("FAIL basic_done: got valid=%b busy=%b cnt=%0d a=%0d want 0 0 1 5",
                     rsp_valid, busy, op_count, alu_a);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        pa[0] = 32'd9; pb[0] = 32'd9; pop[0] = 4'b0110;
        pa[1] = $urandom; pb[1] = 32'd1; pop[1] = 4'b0100; psh[1] = 5'd4;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (req_ready !== ((k % 2) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL alt_grant%0d: got %b want %b", k, req_ready,
                         (k % 2) ? 2'b10 : 2'b01);
            end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if ((k % 2) == 0 && {rsp_valid, rsp_id, rsp_result, rsp_zero} !== {2'b10, 32'd0, 1'b1}) begin
                failures++;
                $display("FAIL alt_rsp%0d: got v=%b id=%b res=%0d z=%b want 1 0 0 1",
                         k, rsp_valid, rsp_id, rsp_result, rsp_zero);
            end else if ((k % 2) == 1 && {rsp_valid, rsp_id, rsp_result, rsp_zero} !== {2'b11, 32'd16, 1'b0}) begin
                failures++;
                $display("FAIL alt_rsp%0d: got v=%b id=%b res=%0d z=%b want 1 1 16 0",
                         k, rsp_valid, rsp_id, rsp_result, rsp_zero);
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_res;
        do_reset();
        pa[0] = $urandom; pb[0] = $urandom; pop[0] = 4'b0010;
        exp_res = pa[0] + pb[0];
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        @(negedge clk);
        pa[1] = $urandom; pb[1] = $urandom; pop[1] = 4'b0001;
        req_valid = 2'b10;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_result, busy, req_ready} !== {2'b10, exp_res, 3'b100}) begin
                failures++;
                $display("FAIL bp_hold%0d: got v=%b id=%b res=%h busy=%b rdy=%b want 1 0 %h 1 00",
                         k, rsp_valid, rsp_id, rsp_result, busy, req_ready, exp_res);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            failures++; $display("FAIL bp_ready_resp: got %b want 00", req_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, op_count, req_ready} !== {1'b0, 16'd1, 2'b10}) begin
            failures++;
            $display("FAIL bp_release: got v=%b cnt=%0d rdy=%b want 0 1 10",
                     rsp_valid, op_count, req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_illegal();
        do_reset();
        pa[1] = $urandom; pb[1] = $urandom; pop[1] = 4'b1111;
        req_valid = 2'b10;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b10) begin
            failures++; $display("FAIL ill_ready: got %b want 10", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_err, rsp_result, rsp_zero, rsp_id} !== {2'b11, 32'd0, 2'b01}) begin
            failures++;
            $display("FAIL ill_rsp: got v=%b err=%b res=%h z=%b id=%b want 1 1 0 0 1",
                     rsp_valid, rsp_err, rsp_result, rsp_zero, rsp_id);
        end
        @(negedge clk);
        checks++;
        if ({op_count, rsp_err, rsp_valid} !== {16'd1, 2'b00}) begin
            failures++;
            $display("FAIL ill_done: got cnt=%0d err=%b v=%b want 1 0 0", op_count, rsp_err, rsp_valid);
        end
    endtask

    task automatic test_reset_exec();
        do_reset();
        pa[0] = 32'd3; pb[0] = 32'd4; pop[0] = 4'b0010;
        pa[1] = 32'd1; pb[1] = 32'd2; pop[1] = 4'b0001;
        req_valid = 2'b10;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b00;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL rx_busy: got %b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, busy, op_count,
             alu_a, alu_b, alu_op, alu_shamt} !== '0) begin
            failures++;
            $display("FAIL rx_async: got v=%b id=%b busy=%b cnt=%h a=%h b=%h op=%h",
                     rsp_valid, rsp_id, busy, op_count, alu_a, alu_b, alu_op);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, busy} !== 2'b00) begin
                failures++;
                $display("FAIL rx_no_rsp%0d: got v=%b busy=%b want 0 0", k, rsp_valid, busy);
            end
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            failures++; $display("FAIL rx_first_grant: got %b want 01", req_ready);
        end
        @(negedge clk);
        req_valid = 2'b00;
    endtask

    task automatic test_wrap();
        do_reset();
        pa[0] = 32'd1; pb[0] = 32'd1; pop[0] = 4'b0010;
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        repeat (45) @(negedge clk);
        checks++;
        if ({w_op_count, op_count} !== {4'hF, 16'd15}) begin
            failures++;
            $display("FAIL wrap_pre: got narrow=%h wide=%0d want f 15", w_op_count, op_count);
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({w_op_count, op_count} !== {4'h0, 16'd16}) begin
            failures++;
            $display("FAIL wrap_post: got narrow=%h wide=%0d want 0 16", w_op_count, op_count);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_random(input int ncyc);
        rsp_t        q[$];
        rsp_t        e;
        logic        last;
        logic        outstanding;
        logic        completing;
        logic        exp_v;
        logic [1:0]  acc;
        logic [1:0]  exp_rdy;
        int          age;
        do_reset();
        last = 1'b1; outstanding = 1'b0; completing = 1'b0; acc = 2'b00; age = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (completing) begin
                model_count++;
                void'(q.pop_front());
                outstanding = 1'b0;
                completing  = 1'b0;
            end
            if (outstanding) age++;
            exp_v = outstanding && (age >= 2);
            checks++;
            if ({rsp_valid, busy, op_count, w_op_count} !==
                {exp_v, outstanding, 16'(model_count), 4'(model_count)}) begin
                failures++;
                $display("FAIL rnd_state@%0d: got v=%b busy=%b cnt=%0d ncnt=%0d want %b %b %0d %0d",
                         c, rsp_valid, busy, op_count, w_op_count, exp_v, outstanding,
                         16'(model_count), 4'(model_count));
            end
            if (exp_v && q.size() > 0) begin
                e = q[0];
                checks++;
                if ({rsp_id, rsp_result, rsp_zero, rsp_err} !== {e.id, e.res, e.zero, e.err}) begin
                    failures++;
                    $display("FAIL rnd_rsp@%0d: got id=%b res=%h z=%b err=%b want %b %h %b %b",
                             c, rsp_id, rsp_result, rsp_zero, rsp_err, e.id, e.res, e.zero, e.err);
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            if (exp_v && rsp_ready) completing = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    req_valid[i] = 1'b0;
                    acc[i] = 1'b0;
                end
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pa[i]  = $urandom;
                        pb[i]  = ($urandom_range(0, 3) == 0) ? pa[i] : $urandom;
                        psh[i] = 5'($urandom_range(0, 31));
                        case ($urandom_range(0, 6))
                            0: pop[i] = 4'd0;
                            1: pop[i] = 4'd1;
                            2: pop[i] = 4'd2;
                            3: pop[i] = 4'd6;
                            4: pop[i] = 4'd4;
                            5: pop[i] = 4'd5;
                            default: pop[i] = 4'($urandom_range(7, 15));
                        endcase
                        req_valid[i] = 1'b1;
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            #1;
            exp_rdy = 2'b00;
            if (!outstanding) begin
                if (req_valid[~last])     exp_rdy[~last] = 1'b1;
                else if (req_valid[last]) exp_rdy[last]  = 1'b1;
            end
            checks++;
            if (req_ready !== exp_rdy) begin
                failures++;
                $display("FAIL rnd_ready@%0d: got %b want %b", c, req_ready, exp_rdy);
            end
            if (exp_rdy != 2'b00) begin
                e.id = exp_rdy[1];
                if (ref_legal(pop[e.id])) begin
                    e.res  = ref_alu(pa[e.id], pb[e.id], pop[e.id], psh[e.id]);
                    e.zero = (e.res == 32'd0);
                    e.err  = 1'b0;
                end else begin
                    e.res = 32'd0; e.zero = 1'b0; e.err = 1'b1;
                end
                q.push_back(e);
                last        = e.id;
                outstanding = 1'b1;
                age         = 0;
                acc[e.id]   = 1'b1;
            end
        end
        req_valid = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_alternate();
        test_backpressure();
        test_illegal();
        test_reset_exec();
        test_wrap();
        test_random(1500);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
